// File: rtl/systolic_skew_feeder_if.sv
// Operand handshake and skewed array-edge bundle for the systolic skew feeder.
// The feeder takes the slave side; the operand source / array edge takes the master side.
interface systolic_skew_feeder_if #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256
);
  logic             InValid;
  logic             InReady;
  logic             InLast;
  logic [WIDTH-1:0] InData  [0:LENGTH-1];
  logic [WIDTH-1:0] WData   [0:LENGTH-1];
  logic [WIDTH-1:0] Inputs  [0:LENGTH-1];
  logic [WIDTH-1:0] Weights [0:LENGTH-1];
  logic             EN;
  logic             Busy;
  logic             Done;

  modport master (
    output InValid, InLast, InData, WData,
    input  InReady, Inputs, Weights, EN, Busy, Done
  );

  modport slave (
    input  InValid, InLast, InData, WData,
    output InReady, Inputs, Weights, EN, Busy, Done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder: lane k of each operand is delayed k cycles, followed by a
// zero flush of LENGTH+DRAIN cycles and a one-cycle Done pulse per tile.
module systolic_skew_feeder #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256,
  parameter int DRAIN  = 0
) (
  input  logic                        CLK,
  input  logic                        SYNC_RST,
  systolic_skew_feeder_if.slave       bus
);

  localparam int CNT_W = $clog2(LENGTH + DRAIN);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(LENGTH + DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef struct packed {
    logic ready;
    logic en;
    logic busy;
    logic done;
  } ctrl_t;

  state_t           state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] flush_cnt;
  logic             accept;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c.ready = (s == S_IDLE) || (s == S_FEED);
    c.en    = (s == S_FEED) || (s == S_FLUSH);
    c.busy  = (s != S_IDLE);
    c.done  = (s == S_DONE);
    return c;
  endfunction

  assign accept      = bus.InValid && ctrl.ready;
  assign bus.InReady = ctrl.ready;
  assign bus.EN      = ctrl.en;
  assign bus.Busy    = ctrl.busy;
  assign bus.Done    = ctrl.done;

  // Outputs are decoded from the next state and registered with it, so they
  // change on the same edge as the state and never glitch.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state     <= S_IDLE;
      ctrl      <= decode(S_IDLE);
      flush_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_FEED: begin
          if (accept) begin
            if (bus.InLast) begin
              state     <= S_FLUSH;
              ctrl      <= decode(S_FLUSH);
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= S_FEED;
              ctrl  <= decode(S_FEED);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= S_DONE;
            ctrl  <= decode(S_DONE);
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ctrl  <= decode(S_IDLE);
        end
        default: begin
          state <= S_IDLE;
          ctrl  <= decode(S_IDLE);
        end
      endcase
    end
  end

  // Lane k: k+1 stages; non-accept cycles load zero, so bubbles and the flush
  // travel down every lane in lockstep with the data.
  for (genvar k = 0; k < LENGTH; k++) begin : g_lane
    logic [WIDTH-1:0] a_sr [0:k];
    logic [WIDTH-1:0] w_sr [0:k];

    // NOTE: the skew storage is reset explicitly because the array must see
    // zeros on every lane right after reset; storage without that need can skip it.
    always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
        for (int j = 0; j <= k; j++) begin
          a_sr[j] <= '0;
          w_sr[j] <= '0;
        end
      end else begin
        a_sr[0] <= accept ? bus.InData[k] : '0;
        w_sr[0] <= accept ? bus.WData[k]  : '0;
        for (int j = 1; j <= k; j++) begin
          a_sr[j] <= a_sr[j-1];
          w_sr[j] <= w_sr[j-1];
        end
      end
    end

    assign bus.Inputs[k]  = a_sr[k];
    assign bus.Weights[k] = w_sr[k];
  end

endmodule
